// File: rtl/regfile_pkg.sv
// Shared widths, control encodings and the per-port read mux for the
// general-purpose register file.
package regfile_pkg;

    localparam int          REG_BUS         = 32;
    localparam int          REG_ADDR_BUS    = 5;
    localparam int          REG_NUM_DEFAULT = 32;
    localparam logic        RST_ENABLE      = 1'b0;
    localparam logic        WRITE_ENABLE    = 1'b1;
    localparam logic        READ_ENABLE     = 1'b1;
    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;

    typedef logic [REG_BUS-1:0]      reg_word_t;
    typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

    // Read value for one port: reset > disabled > $zero > same-cycle bypass > array
    function automatic reg_word_t read_mux(
        input logic      rst_v,
        input logic      re,
        input reg_addr_t raddr,
        input logic      we,
        input reg_addr_t waddr,
        input reg_word_t wdata,
        input reg_word_t stored
    );
        reg_word_t r;
        if (rst_v == RST_ENABLE) begin
            r = ZERO_WORD;
        end else if (re != READ_ENABLE) begin
            r = ZERO_WORD;
        end else if (raddr == {REG_ADDR_BUS{1'b0}}) begin
            r = ZERO_WORD;
        end else if ((we == WRITE_ENABLE) && (waddr == raddr)) begin
            r = wdata;
        end else begin
            r = stored;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile.sv
// Two-read / one-write register file with $zero hardwired, write-through
// bypass, a registered debug read port and a committed-write counter.
module regfile
    import regfile_pkg::*;
#(
    parameter int REG_NUM      = REG_NUM_DEFAULT,
    parameter int REG_NUM_LOG2 = REG_ADDR_BUS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [REG_NUM_LOG2-1:0] waddr,
    input  logic [REG_BUS-1:0]      wdata,
    input  logic                    re1,
    input  logic [REG_NUM_LOG2-1:0] raddr1,
    output logic [REG_BUS-1:0]      rdata1,
    input  logic                    re2,
    input  logic [REG_NUM_LOG2-1:0] raddr2,
    output logic [REG_BUS-1:0]      rdata2,
    input  logic [REG_NUM_LOG2-1:0] dbg_raddr,
    output logic [REG_BUS-1:0]      dbg_rdata,
    output logic [REG_BUS-1:0]      wr_count
);

    reg_word_t mem_r [REG_NUM];
    reg_word_t dbg_rdata_r;
    reg_word_t wr_count_r;
    reg_word_t dbg_next_s;
    logic      commit_s;

    // Writes to $zero are dropped entirely, so they neither store nor count
    assign commit_s = (we == WRITE_ENABLE) && (waddr != {REG_NUM_LOG2{1'b0}});

    // Register array; entry 0 is cleared on reset and never written afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_r[i] <= ZERO_WORD;
            end
        end else if (commit_s) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    // Debug read is write-first: it sees the value committed at the same edge
    always_comb begin
        dbg_next_s = ZERO_WORD;
        if (dbg_raddr == {REG_NUM_LOG2{1'b0}}) begin
            dbg_next_s = ZERO_WORD;
        end else if (commit_s && (waddr == dbg_raddr)) begin
            dbg_next_s = wdata;
        end else begin
            dbg_next_s = mem_r[dbg_raddr];
        end
    end

    // Debug data register and committed-write counter (wraps silently)
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            dbg_rdata_r <= ZERO_WORD;
            wr_count_r  <= ZERO_WORD;
        end else begin
            dbg_rdata_r <= dbg_next_s;
            if (commit_s) begin
                wr_count_r <= wr_count_r + 32'd1;
            end else begin
                wr_count_r <= wr_count_r;
            end
        end
    end

    // Combinational read ports share one mux definition
    always_comb begin
        rdata1 = read_mux(rst, re1, raddr1, we, waddr, wdata, mem_r[raddr1]);
        rdata2 = read_mux(rst, re2, raddr2, we, waddr, wdata, mem_r[raddr2]);
    end

    assign dbg_rdata = dbg_rdata_r;
    assign wr_count  = wr_count_r;

endmodule
